// File: rtl/fifo_pkg.sv
// Shared helpers for the FWFT FIFO: width calculation and wrapping pointer increment.
package fifo_pkg;

  // Returns ceil(log2(n)). Called as clog2(DEPTH+1) to size a 0..DEPTH counter.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Wrap explicitly at depth-1 so non-power-of-two depths work.
  function automatic int unsigned ptr_inc(input int unsigned p, input int unsigned depth);
    return (p == depth - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// WIDTH x DEPTH storage: one write port, one asynchronous read port, no reset.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 7,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_fwft_sync.sv
// Circular-buffer FIFO with first-word-fall-through output, level flags,
// synchronous flush and sticky overflow/underflow flags.
module fifo_fwft_sync
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH      = 7,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned AFULL_LVL  = DEPTH - 1,
  parameter int unsigned AEMPTY_LVL = 1,
  localparam int unsigned CW = clog2(DEPTH + 1),
  localparam int unsigned PW = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] rdata;
  logic             push_ok, pop_ok;

  assign empty        = (count == '0);
  assign full         = (count == CW'(DEPTH));
  assign almost_empty = (32'(count) <= AEMPTY_LVL);
  assign almost_full  = (32'(count) >= AFULL_LVL);

  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;

  fifo_ram #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_ram (
    .clk   (clk),
    .we    (push_ok & ~flush),
    .waddr (wr_ptr),
    .wdata (din),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  assign dout = empty ? '0 : rdata;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= PW'(ptr_inc(32'(wr_ptr), DEPTH));
      if (pop_ok)  rd_ptr <= PW'(ptr_inc(32'(rd_ptr), DEPTH));
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push & ~push_ok) overflow  <= 1'b1;
      if (pop & ~pop_ok)   underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_fwft_sync.sv
// Directed bench for fifo_fwft_sync (DEPTH=7, WIDTH=8) with hand-computed expectations.
module tb_fifo_fwft_sync;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       flush = 1'b0;
  logic       push = 1'b0;
  logic [7:0] din = 8'h00;
  logic       pop = 1'b0;
  logic [7:0] dout;
  logic       empty, full, almost_empty, almost_full, overflow, underflow;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  fifo_fwft_sync #(.DEPTH(7), .WIDTH(8)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .flush        (flush),
    .push         (push),
    .din          (din),
    .pop          (pop),
    .dout         (dout),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_aempty", 32'(almost_empty), 1);
    chk("rst_afull", 32'(almost_full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_udf", 32'(underflow), 0);
    #1 rstn = 1'b1;
    step();
    chk("idle_count", 32'(count), 0);

    // fill 0x11..0x17
    for (int i = 0; i < 7; i++) begin
      push = 1'b1; din = 8'(8'h11 + i);
      step();
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_afull", 32'(almost_full), (i + 1 >= 6) ? 1 : 0);
      chk("fill_full", 32'(full), (i == 6) ? 1 : 0);
      chk("fill_dout", 32'(dout), 32'h11);
    end
    din = 8'hFF;
    step();
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 7);
    push = 1'b0;

    // drain in order
    for (int i = 0; i < 7; i++) begin
      chk("drain_dout", 32'(dout), 32'(8'h11 + i));
      pop = 1'b1;
      step();
    end
    pop = 1'b0;
    chk("drain_empty", 32'(empty), 1);
    chk("drain_dout0", 32'(dout), 0);
    chk("drain_aempty", 32'(almost_empty), 1);

    flush = 1'b1; step(); flush = 1'b0;
    chk("flush_ovf", 32'(overflow), 0);

    // full with simultaneous push/pop
    for (int i = 0; i < 7; i++) begin
      push = 1'b1; din = 8'(8'h21 + i);
      step();
    end
    din = 8'hAA; pop = 1'b1;
    step();
    push = 1'b0; pop = 1'b0;
    chk("fpp_count", 32'(count), 7);
    chk("fpp_ovf", 32'(overflow), 0);
    for (int i = 0; i < 7; i++) begin
      chk("fpp_dout", 32'(dout), (i == 6) ? 32'hAA : 32'(8'h22 + i));
      pop = 1'b1;
      step();
    end
    pop = 1'b0;
    chk("fpp_empty", 32'(empty), 1);

    // empty with simultaneous push/pop
    push = 1'b1; pop = 1'b1; din = 8'h5C;
    step();
    push = 1'b0; pop = 1'b0;
    chk("epp_count", 32'(count), 1);
    chk("epp_udf", 32'(underflow), 1);
    chk("epp_dout", 32'(dout), 32'h5C);
    pop = 1'b1; step(); pop = 1'b0;
    flush = 1'b1; step(); flush = 1'b0;
    chk("flush_udf", 32'(underflow), 0);

    // wrap through the non-power-of-two buffer
    for (int i = 0; i < 20; i++) begin
      push = 1'b1; din = 8'(i);
      step();
      push = 1'b0;
      chk("wrap_cnt1", 32'(count), 1);
      chk("wrap_dout", 32'(dout), 32'(i));
      pop = 1'b1;
      step();
      pop = 1'b0;
      chk("wrap_cnt0", 32'(count), 0);
    end
    chk("wrap_ovf", 32'(overflow), 0);
    chk("wrap_udf", 32'(underflow), 0);

    // pop on empty, then 4 pushes, then flush with a push
    pop = 1'b1; step(); pop = 1'b0;
    chk("pe_udf", 32'(underflow), 1);
    chk("pe_count", 32'(count), 0);
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; din = 8'(8'h40 + i);
      step();
    end
    chk("pre_flush_cnt", 32'(count), 4);
    flush = 1'b1; din = 8'h99;
    step();
    flush = 1'b0; push = 1'b0;
    chk("fl_count", 32'(count), 0);
    chk("fl_empty", 32'(empty), 1);
    chk("fl_udf", 32'(underflow), 0);
    chk("fl_dout", 32'(dout), 0);
    step();
    chk("fl_no99", 32'(count), 0);

    // async reset mid-burst
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; din = 8'(8'h60 + i);
      step();
    end
    chk("burst_cnt", 32'(count), 3);
    #2 rstn = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_dout", 32'(dout), 0);
    push = 1'b0;
    step();
    rstn = 1'b1;
    step();
    chk("post_rst_cnt", 32'(count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
